tile_map_fetcher: RTL and testbench
===================================

Name: tile_map_fetcher

Overview:
- Parametrised successor to the VGA tile-select stage.
- Converts raster position (hcount/vcount) into a tile index plus an in-tile pixel coordinate for the downstream tile ROM/colour stage.
- Adds per-frame latched X/Y scroll with wrap-around, configurable tile size, index width and map size.
- Adds an explicit row-fetch handshake to the external map memory and a one-row line buffer.

Parameters:
- H_LEFT, 144, first active hcount.
- V_TOP, 31, first active vcount.
- TILE_SHIFT, 3, log2 of tile edge in pixels (tile = 2^TILE_SHIFT square).
- IDX_W, 4, tile index width.
- MAP_COLS, 80, map width in tiles.
- MAP_ROWS, 60, map height in tiles.
- ROW_AW, 6, map row address width (2^ROW_AW >= MAP_ROWS).
- ENT_W, IDX_W (IDX_W+2 with TILE_FLIP_EN), map entry width.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- hcount  in  10  raster horizontal counter.
- vcount  in  10  raster vertical counter.
- bright  in  1  active-video flag from the sync generator.
- scroll_x  in  16  requested horizontal scroll, pixels.
- scroll_y  in  16  requested vertical scroll, pixels.
- row_rd_en  out  1  map row read strobe.
- row_addr  out  ROW_AW  map row address.
- row_data  in  MAP_COLS*ENT_W  map row, valid exactly 1 cycle after row_rd_en.
- tile_idx  out  IDX_W  selected tile index.
- tile_px  out  TILE_SHIFT  pixel x within tile.
- tile_py  out  TILE_SHIFT  pixel y within tile.
- tile_valid  out  1  outputs meaningful.
- scroll_err  out  1  one-cycle pulse: out-of-range scroll rejected.

Behaviour:
- Reset (rst=0, async) clears:
  - all outputs to 0;
  - shadow scroll registers to 0;
  - line buffer to 0;
  - fetch FSM to IDLE.
- Derived constants: MAP_PX_W = MAP_COLS<<TILE_SHIFT; MAP_PX_H = MAP_ROWS<<TILE_SHIFT.
- Scroll latch (frame start, hcount==0 && vcount==0):
  - sx_sh <= scroll_x if scroll_x < MAP_PX_W; otherwise retain the old value and pulse scroll_err.
  - sy_sh is updated the same way against MAP_PX_H.
  - If both axes are rejected, scroll_err is still a single pulse.
  - Scroll changes mid-frame have no effect.
- Map coordinates, where py = vcount-V_TOP and px = hcount-H_LEFT:
  - my = py+sy_sh, minus MAP_PX_H if >= MAP_PX_H.
  - mx = px+sx_sh, minus MAP_PX_W if >= MAP_PX_W.
  - Single conditional subtract; sums carry one extra bit.
- Fetch FSM:
  - IDLE -> REQ at hcount==0 when V_TOP <= vcount < V_TOP+480.
  - REQ: row_rd_en=1 for exactly one cycle; row_addr = my>>TILE_SHIFT.
  - REQ -> WAIT; in WAIT the line buffer captures row_data.
  - WAIT -> IDLE.
  - The buffer is stable from hcount==2 onward, well before H_LEFT.
  - Blank lines issue no fetch.
  - Reset in REQ/WAIT aborts the fetch; the buffer stays 0.
- Output pipeline, 2 cycles:
  - S1 registers mx, my[TILE_SHIFT-1:0] and bright.
  - S2 sets:
    - tile_idx = entry[mx>>TILE_SHIFT] low IDX_W bits;
    - tile_px = mx[TILE_SHIFT-1:0];
    - tile_py = registered y bits;
    - tile_valid = S1 bright.
  - When bright=0: tile_valid=0 and tile_idx/tile_px/tile_py are forced to 0.
- Wrap: a column past MAP_COLS-1 selects column 0 on the same line with no bubble. A row past MAP_ROWS-1 wraps to row 0.

Optional Feature:
- TILE_FLIP_EN defined:
  - Entry bit IDX_W is hflip and bit IDX_W+1 is vflip.
  - tile_px becomes ~tile_px when hflip is set; tile_py becomes ~tile_py when vflip is set.
  - The flip bits are registered alongside the index; latency is unchanged.
- Undefined:
  - ENT_W = IDX_W; no flip logic.
  - tile_px/tile_py pass through unmodified.

Decomposition:
- Package tile_map_pkg holds:
  - the default H_LEFT/V_TOP/480x640 constants;
  - the MAP_PX_W/MAP_PX_H functions;
  - the fetch FSM state enum (IDLE, REQ, WAIT);
  - the flip-bit offsets.
- One sub-module, tile_wrap_add: parametrised adder with conditional modulo subtract, instantiated for the X and Y axes.

Test Plan:
- Reset: rst=0 mid-line with WAIT pending -> all outputs 0, row_rd_en=0, no buffer update; after release, the next active line's hcount==0 fetch proceeds normally.
- No scroll, map[0][0]=5, map[0][1]=9:
  - vcount=31, hcount=144 -> two cycles later tile_idx=5, tile_px=0, tile_py=0, tile_valid=1.
  - At hcount=152 (+2 cycles) -> tile_idx=9.
- Fetch handshake: at vcount=40 -> row_rd_en high one cycle at hcount==0 (registered), row_addr=1; no strobe at vcount=10.
- Horizontal wrap: scroll_x=636 latched at frame start, map[0][79]=3, map[0][0]=7 -> px 0..3 give idx 3 with tile_px 4..7; px 4 gives idx 7, tile_px 0.
- Scroll latch:
  - scroll_y=8 changed mid-frame -> unchanged until next frame; then the first active line fetches row_addr=1.
  - scroll_x=640 -> scroll_err pulse, sx_sh retained.
- TILE_FLIP_EN: entry {vflip=1, hflip=1, idx=2}, no scroll -> at px=1, py=2 outputs tile_idx=2, tile_px=6, tile_py=5.

Source files
------------

// File: rtl/tile_map_pkg.sv
// rtl/tile_map_pkg.sv - shared constants, fetch state enum and map-size helpers for tile_map_fetcher
// Optional TILE_FLIP_EN widens map entries by two flip bits.
package tile_map_pkg;

  localparam int H_LEFT_DEF = 144;
  localparam int V_TOP_DEF  = 31;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;

  // Flip bits sit directly above the tile index within a map entry.
  localparam int HFLIP_OFS = 0;
  localparam int VFLIP_OFS = 1;
`ifdef TILE_FLIP_EN
  localparam int FLIP_BITS = 2;
`else
  localparam int FLIP_BITS = 0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;

  function automatic int map_px_w(input int cols, input int tile_shift);
    return cols << tile_shift;
  endfunction

  function automatic int map_px_h(input int rows, input int tile_shift);
    return rows << tile_shift;
  endfunction

endpackage

// File: rtl/tile_wrap_add.sv
// rtl/tile_wrap_add.sv - adder with a single conditional modulo subtract
// Inputs must each be below MOD so one subtract is enough to wrap.
module tile_wrap_add #(
  parameter int W   = 16,
  parameter int MOD = 640
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  localparam logic [W:0] MOD_V = (W+1)'(MOD);

  logic [W:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    y   = (sum >= MOD_V) ? W'(sum - MOD_V) : sum[W-1:0];
  end

endmodule

// File: rtl/tile_map_fetcher.sv
// rtl/tile_map_fetcher.sv - raster to tile index/pixel with scroll, row fetch and line buffer
// Define TILE_FLIP_EN to enable per-entry horizontal/vertical flip bits.
module tile_map_fetcher
  import tile_map_pkg::*;
#(
  parameter int H_LEFT     = H_LEFT_DEF,
  parameter int V_TOP      = V_TOP_DEF,
  parameter int TILE_SHIFT = 3,
  parameter int IDX_W      = 4,
  parameter int MAP_COLS   = 80,
  parameter int MAP_ROWS   = 60,
  parameter int ROW_AW     = 6,
  parameter int ENT_W      = IDX_W + FLIP_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [9:0]                hcount,
  input  logic [9:0]                vcount,
  input  logic                      bright,
  input  logic [15:0]               scroll_x,
  input  logic [15:0]               scroll_y,
  output logic                      row_rd_en,
  output logic [ROW_AW-1:0]         row_addr,
  input  logic [MAP_COLS*ENT_W-1:0] row_data,
  output logic [IDX_W-1:0]          tile_idx,
  output logic [TILE_SHIFT-1:0]     tile_px,
  output logic [TILE_SHIFT-1:0]     tile_py,
  output logic                      tile_valid,
  output logic                      scroll_err
);

  localparam int          PX_W   = map_px_w(MAP_COLS, TILE_SHIFT);
  localparam int          PX_H   = map_px_h(MAP_ROWS, TILE_SHIFT);
  localparam logic [15:0] PX_W16 = 16'(PX_W);
  localparam logic [15:0] PX_H16 = 16'(PX_H);

  logic [15:0] sx_sh, sy_sh, px, py, mx, my;
  logic        frame_start, line_active;

  assign px          = {6'd0, hcount - 10'(H_LEFT)};
  assign py          = {6'd0, vcount - 10'(V_TOP)};
  assign frame_start = (hcount == 10'd0) && (vcount == 10'd0);
  assign line_active = (vcount >= 10'(V_TOP)) && (vcount < 10'(V_TOP + V_ACTIVE));

  tile_wrap_add #(.W(16), .MOD(PX_W)) u_wrap_x (.a(px), .b(sx_sh), .y(mx));
  tile_wrap_add #(.W(16), .MOD(PX_H)) u_wrap_y (.a(py), .b(sy_sh), .y(my));

  // Out-of-range requests keep the previous shadow value for that axis.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sx_sh      <= '0;
      sy_sh      <= '0;
      scroll_err <= 1'b0;
    end else begin
      scroll_err <= 1'b0;
      if (frame_start) begin
        if (scroll_x < PX_W16) sx_sh <= scroll_x;
        if (scroll_y < PX_H16) sy_sh <= scroll_y;
        scroll_err <= (scroll_x >= PX_W16) || (scroll_y >= PX_H16);
      end
    end
  end

  fetch_state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hcount == 10'd0 && line_active) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign row_rd_en = (state_q == REQ);

  logic [MAP_COLS*ENT_W-1:0] lbuf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_addr <= '0;
      lbuf     <= '0;
    end else begin
      if (state_q == IDLE && state_d == REQ) row_addr <= ROW_AW'(my >> TILE_SHIFT);
      if (state_q == WAIT) lbuf <= row_data;
    end
  end

  logic [15:0]           s1_mx;
  logic [TILE_SHIFT-1:0] s1_py;
  logic                  s1_bright;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_mx     <= '0;
      s1_py     <= '0;
      s1_bright <= 1'b0;
    end else begin
      s1_mx     <= mx;
      s1_py     <= my[TILE_SHIFT-1:0];
      s1_bright <= bright;
    end
  end

  logic [15:0]           col;
  logic [ENT_W-1:0]      entry;
  logic [TILE_SHIFT-1:0] px_n, py_n;

  always_comb begin
    col   = s1_mx >> TILE_SHIFT;
    entry = '0;
    for (int c = 0; c < MAP_COLS; c++)
      if (col == 16'(c)) entry = lbuf[c*ENT_W +: ENT_W];
`ifdef TILE_FLIP_EN
    px_n = entry[IDX_W+HFLIP_OFS] ? ~s1_mx[TILE_SHIFT-1:0] : s1_mx[TILE_SHIFT-1:0];
    py_n = entry[IDX_W+VFLIP_OFS] ? ~s1_py : s1_py;
`else
    px_n = s1_mx[TILE_SHIFT-1:0];
    py_n = s1_py;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tile_idx   <= '0;
      tile_px    <= '0;
      tile_py    <= '0;
      tile_valid <= 1'b0;
    end else begin
      tile_valid <= s1_bright;
      tile_idx   <= s1_bright ? entry[IDX_W-1:0] : '0;
      tile_px    <= s1_bright ? px_n : '0;
      tile_py    <= s1_bright ? py_n : '0;
    end
  end

endmodule

// File: tb/tb_tile_map_fetcher.sv
// tb/tb_tile_map_fetcher.sv - scoreboard bench for tile_map_fetcher
// Honours TILE_FLIP_EN when the design is built with it.
module tb_tile_map_fetcher;
  import tile_map_pkg::*;

  localparam int ENTW = 4 + FLIP_BITS;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [9:0]       hcount = '0, vcount = '0;
  logic             bright = 1'b0;
  logic [15:0]      scroll_x = '0, scroll_y = '0;
  logic             row_rd_en;
  logic [5:0]       row_addr;
  logic [80*ENTW-1:0] row_data = '1;
  logic [3:0]       tile_idx;
  logic [2:0]       tile_px, tile_py;
  logic             tile_valid, scroll_err;

  tile_map_fetcher dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .bright(bright),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .row_rd_en(row_rd_en), .row_addr(row_addr),
    .row_data(row_data), .tile_idx(tile_idx), .tile_px(tile_px), .tile_py(tile_py),
    .tile_valid(tile_valid), .scroll_err(scroll_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [ENTW-1:0] map_mem [60][80];
  logic [ENTW-1:0] mbuf [80];
  int m_sx = 0, m_sy = 0;
  logic [31:0] pix_q [$];
  int fetch_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_pix(input int h, input int v);
    int mx, my;
    logic [ENTW-1:0] e;
    logic [2:0] tx, ty;
    mx = (h - 144 + m_sx) % 640;
    my = (v - 31 + m_sy) % 480;
    e  = mbuf[mx / 8];
    tx = 3'(mx % 8);
    ty = 3'(my % 8);
`ifdef TILE_FLIP_EN
    if (e[4]) tx = ~tx;
    if (e[5]) ty = ~ty;
`endif
    return 32'({e[3:0], tx, ty});
  endfunction

  function automatic logic [80*ENTW-1:0] pack_row(input int r);
    logic [80*ENTW-1:0] d;
    for (int c = 0; c < 80; c++) d[c*ENTW +: ENTW] = map_mem[r][c];
    return d;
  endfunction

  // Map memory model: data presented only in the cycle after the strobe.
  int  pend_addr = 0;
  bit  pend = 1'b0;
  always @(negedge clk) begin
    if (pend) begin
      row_data = pack_row(pend_addr);
      pend = 1'b0;
    end else row_data = '1;
    if (row_rd_en) begin
      check("fetch_expected", 32'(fetch_q.size() > 0), 1);
      if (fetch_q.size() > 0) check("row_addr", 32'(row_addr), 32'(fetch_q.pop_front()));
      pend_addr = int'(row_addr);
      pend = 1'b1;
    end
  end

  logic [31:0] mon_e;
  always @(negedge clk) begin
    if (tile_valid) begin
      check("pix_expected", 32'(pix_q.size() > 0), 1);
      if (pix_q.size() > 0) begin
        mon_e = pix_q.pop_front();
        check("tile_out", 32'({tile_idx, tile_px, tile_py}), mon_e);
      end
    end else check("blank_zero", 32'({tile_idx, tile_px, tile_py}), 0);
  end

  task automatic drive(input int h, input int v, input bit b);
    @(negedge clk);
    hcount = 10'(h);
    vcount = 10'(v);
    bright = b;
  endtask

  task automatic push_fetch(input int v);
    int a;
    if (v >= 31 && v < 511) begin
      a = ((v - 31 + m_sy) % 480) / 8;
      fetch_q.push_back(a);
      for (int c = 0; c < 80; c++) mbuf[c] = map_mem[a][c];
    end
  endtask

  task automatic do_line(input int v, input int h0, input int n, input bit fetch);
    if (fetch) begin
      drive(0, v, 0);
      push_fetch(v);
    end
    for (int h = 1; h < 4; h++) drive(h, v, 0);
    for (int i = 0; i < n; i++) begin
      drive(h0 + i, v, 1);
      pix_q.push_back(exp_pix(h0 + i, v));
    end
    for (int i = 0; i < 3; i++) drive(h0 + n + i, v, 0);
  endtask

  task automatic frame_start(input int sx, input int sy);
    logic exp_err;
    scroll_x = 16'(sx);
    scroll_y = 16'(sy);
    drive(0, 0, 0);
    exp_err = (sx >= 640) || (sy >= 480);
    if (sx < 640) m_sx = sx;
    if (sy < 480) m_sy = sy;
    @(negedge clk);
    check("scroll_err", 32'(scroll_err), 32'(exp_err));
    hcount = 10'd1;
    @(negedge clk);
    check("scroll_err_once", 32'(scroll_err), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < 60; r++)
      for (int c = 0; c < 80; c++) map_mem[r][c] = ENTW'($urandom_range(1, (1 << ENTW) - 1));
    for (int c = 0; c < 80; c++) mbuf[c] = '0;

    repeat (3) @(negedge clk);
    check("rst_valid", 32'(tile_valid), 0);
    check("rst_rd_en", 32'(row_rd_en), 0);
    check("rst_addr", 32'(row_addr), 0);
    check("rst_err", 32'(scroll_err), 0);
    rst = 1'b1;

    map_mem[0][0] = ENTW'(5);
    map_mem[0][1] = ENTW'(9);
    frame_start(0, 0);
    do_line(31, 144, 17, 1);
    do_line(40, 144, 8, 1);
    do_line(10, 144, 0, 1);

    map_mem[0][79] = ENTW'(3);
    map_mem[0][0]  = ENTW'(7);
    frame_start(636, 0);
    do_line(31, 144, 12, 1);
    do_line(31, 764, 20, 1);

    scroll_y = 16'd8;
    do_line(32, 144, 4, 1);
    frame_start(636, 8);
    do_line(31, 144, 6, 1);
    frame_start(640, 8);
    do_line(31, 144, 6, 1);
    frame_start(700, 500);
    do_line(503, 144, 6, 1);

    // Reset lands while the row read is in WAIT: buffer must stay clear.
    drive(0, 45, 0);
    push_fetch(45);
    drive(1, 45, 0);
    drive(2, 45, 0);
    #2 rst = 1'b0;
    for (int c = 0; c < 80; c++) mbuf[c] = '0;
    m_sx = 0;
    m_sy = 0;
    #1;
    check("arst_rd_en", 32'(row_rd_en), 0);
    check("arst_valid", 32'(tile_valid), 0);
    check("arst_addr", 32'(row_addr), 0);
    check("arst_idx", 32'(tile_idx), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_line(50, 144, 6, 0);
    do_line(50, 144, 10, 1);

`ifdef TILE_FLIP_EN
    map_mem[0][0] = {2'b11, 4'd2};
    frame_start(0, 0);
    do_line(33, 144, 4, 1);
`endif

    repeat (4) @(negedge clk);
    check("pix_q_empty", 32'(pix_q.size()), 0);
    check("fetch_q_empty", 32'(fetch_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
